// File: rtl/toy_fetch_mem_resp_if.sv
// toy_fetch_mem_resp_if: fetch request, SRAM read and response signals of toy_fetch_mem_resp.
// slave is the block itself; master is its environment (fetch queue plus SRAM).
interface toy_fetch_mem_resp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int ID_WIDTH   = 7
);
    localparam int IW = ADDR_WIDTH - $clog2(LINE_WIDTH / 8);
    logic                  req_vld;
    logic                  req_rdy;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [ID_WIDTH-1:0]   req_entry_id;
    logic                  sram_en;
    logic                  sram_gnt;
    logic [IW-1:0]         sram_addr;
    logic [LINE_WIDTH-1:0] sram_rdata;
    logic                  ack_vld;
    logic [LINE_WIDTH-1:0] ack_pld;
    logic [ID_WIDTH-1:0]   ack_entry_id;
    modport master (
        output req_vld, req_pc, req_entry_id, sram_gnt, sram_rdata,
        input  req_rdy, sram_en, sram_addr, ack_vld, ack_pld, ack_entry_id
    );
    modport slave (
        input  req_vld, req_pc, req_entry_id, sram_gnt, sram_rdata,
        output req_rdy, sram_en, sram_addr, ack_vld, ack_pld, ack_entry_id
    );
endinterface

// File: rtl/toy_fetch_mem_resp.sv
// toy_fetch_mem_resp: queues fetch requests, reads lines from SRAM and returns them tagged with their entry id.
// Define TOY_FETCH_MEM_RESP_BYPASS_EN to let a request reach the SRAM in its accept cycle when the FIFO is empty.
module toy_fetch_mem_resp #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int ID_WIDTH   = 7,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 2
) (
    input logic clk,
    input logic rst,
    input logic clear,
    toy_fetch_mem_resp_if.slave bus
);
    localparam int OFF = $clog2(LINE_WIDTH / 8);
    localparam int IW  = ADDR_WIDTH - OFF;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    logic [IW-1:0]       r_idx [DEPTH];
    logic [ID_WIDTH-1:0] r_id  [DEPTH];
    logic [PW-1:0]       r_wp, r_rp;
    logic [CW-1:0]       r_cnt;
    logic [LATENCY-1:0]  r_v;
    logic [ID_WIDTH-1:0] r_pid [LATENCY];
    logic                w_empty, w_rdy, w_byp, w_en, w_gnt, w_push, w_pop, w_unused;
    logic [IW-1:0]       w_req_idx, w_addr;
    logic [ID_WIDTH-1:0] w_gid;
    assign w_req_idx = bus.req_pc[ADDR_WIDTH-1:OFF];
    assign w_unused  = ^bus.req_pc[OFF-1:0];
    assign w_empty   = r_cnt == '0;
    assign w_rdy     = ~rst & ~clear & (r_cnt < CW'(DEPTH));
`ifdef TOY_FETCH_MEM_RESP_BYPASS_EN
    assign w_byp     = ~rst & ~clear & w_empty & bus.req_vld;
`else
    assign w_byp     = 1'b0;
`endif
    // With an empty FIFO only a bypassing request can be in front of the SRAM.
    assign w_en      = (~rst & ~clear & ~w_empty) | w_byp;
    assign w_addr    = w_empty ? w_req_idx : r_idx[r_rp];
    assign w_gid     = w_empty ? bus.req_entry_id : r_id[r_rp];
    assign w_gnt     = w_en & bus.sram_gnt;
    assign w_pop     = w_gnt & ~w_empty;
    assign w_push    = bus.req_vld & w_rdy & ~(w_byp & bus.sram_gnt);
    assign bus.req_rdy      = w_rdy;
    assign bus.sram_en      = w_en;
    assign bus.sram_addr    = w_en ? w_addr : '0;
    assign bus.ack_vld      = r_v[LATENCY-1];
    assign bus.ack_entry_id = r_pid[LATENCY-1];
    assign bus.ack_pld      = r_v[LATENCY-1] ? bus.sram_rdata : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_v   <= '0;
        end else if (clear) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_v   <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop) r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_v   <= LATENCY'({r_v, w_gnt});
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) r_pid[i] <= '0;
        end else begin
            r_pid[0] <= w_gid;
            for (int i = 1; i < LATENCY; i++) r_pid[i] <= r_pid[i-1];
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_idx[r_wp] <= w_req_idx;
            r_id[r_wp]  <= bus.req_entry_id;
        end
    end
endmodule

// File: tb/tb_toy_fetch_mem_resp.sv
// tb_toy_fetch_mem_resp: directed bench with an SRAM model and an in-order response scoreboard.
module tb_toy_fetch_mem_resp;
`ifdef TOY_FETCH_MEM_RESP_BYPASS_EN
    localparam int LAT_A = 2;
`else
    localparam int LAT_A = 3;
`endif
    logic clk = 1'b0;
    logic rst, clear;
    int n_tests = 0, n_fail = 0, cyc = 0;
    int ack_cyc [$];
    logic [6:0] exp_q [$];
    logic [27:0] exp_line [128];
    logic [1:0] pv = '0;
    logic [27:0] pa [2];
    toy_fetch_mem_resp_if bus ();
    toy_fetch_mem_resp dut (.clk(clk), .rst(rst), .clear(clear), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [127:0] dat(input logic [27:0] a);
        return {4{4'hC, a}};
    endfunction
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic put(input logic [31:0] pc, input logic [6:0] id);
        bus.req_vld = 1'b1;
        bus.req_pc = pc;
        bus.req_entry_id = id;
    endtask
    task automatic single(input string t, input logic [31:0] pc, input logic [6:0] id);
        @(negedge clk);
        bus.sram_gnt = 1'b1;
        put(pc, id);
        #1 chk({t, "_rdy"}, bus.req_rdy, 1);
        @(negedge clk);
        bus.req_vld = 1'b0;
        #1;
`ifndef TOY_FETCH_MEM_RESP_BYPASS_EN
        chk({t, "_en"}, bus.sram_en, 1);
        chk({t, "_addr"}, bus.sram_addr, pc[31:4]);
`endif
        for (int k = 2; k <= LAT_A; k++) begin
            @(negedge clk);
            chk({t, "_vld"}, bus.ack_vld, k == LAT_A);
        end
        chk({t, "_id"}, bus.ack_entry_id, id);
        @(negedge clk);
        chk({t, "_idle"}, bus.ack_vld, 0);
    endtask
    // SRAM: data for the granted line appears two cycles after the grant, junk otherwise.
    always @(posedge clk) begin
        pv <= {pv[0], bus.sram_en & bus.sram_gnt};
        pa[0] <= bus.sram_addr;
        pa[1] <= pa[0];
    end
    assign bus.sram_rdata = pv[1] ? dat(pa[1]) : {4{32'hDEADBEEF}};
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ack_vld) begin
            ack_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("stale_ack", exp_q.size(), 1);
            else begin
                chk("order", bus.ack_entry_id, exp_q[0]);
                chk("pld", bus.ack_pld, dat(exp_line[exp_q[0]]));
                void'(exp_q.pop_front());
            end
        end
        if (rst || clear) exp_q.delete();
        if (!rst && bus.req_vld && bus.req_rdy) begin
            exp_q.push_back(bus.req_entry_id);
            exp_line[bus.req_entry_id] = bus.req_pc[31:4];
        end
    end
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
    initial begin
        rst = 1'b1;
        clear = 1'b0;
        bus.req_vld = 1'b0;
        bus.req_pc = '0;
        bus.req_entry_id = '0;
        bus.sram_gnt = 1'b0;
        repeat (2) @(negedge clk);
        put(32'hFFF0, 7'd3);
        bus.sram_gnt = 1'b1;
        #1;
        chk("rst_rdy", bus.req_rdy, 0);
        chk("rst_en", bus.sram_en, 0);
        chk("rst_addr", bus.sram_addr, 0);
        chk("rst_vld", bus.ack_vld, 0);
        chk("rst_pld", bus.ack_pld, 0);
        chk("rst_id", bus.ack_entry_id, 0);
        @(negedge clk);
        bus.req_vld = 1'b0;
        rst = 1'b0;
        #1 chk("rel_rdy", bus.req_rdy, 1);
        single("t1", 32'h1010, 7'd5);
        bus.sram_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'h2000 + 32'(i) * 16, 7'(20 + i));
            #1 chk("t2_acc", bus.req_rdy, 1);
            @(negedge clk);
        end
        put(32'h2040, 7'd24);
        #1 chk("t2_full", bus.req_rdy, 0);
        @(negedge clk);
        #1 chk("t2_full2", bus.req_rdy, 0);
        chk("t2_hold_en", bus.sram_en, 1);
        bus.sram_gnt = 1'b1;
        #1 chk("t2_gnt_rdy", bus.req_rdy, 0);
        @(negedge clk);
        #1 chk("t2_5th", bus.req_rdy, 1);
        @(negedge clk);
        bus.req_vld = 1'b0;
        repeat (8) @(negedge clk);
        chk("t2_drain", exp_q.size(), 0);
        bus.sram_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(32'h3000 + 32'(i) * 16, 7'(9 + i));
            #1 chk("t3_acc", bus.req_rdy, 1);
            @(negedge clk);
        end
        bus.req_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_en", bus.sram_en, 1);
            chk("t3_addr", bus.sram_addr, 28'h300);
            @(negedge clk);
        end
        bus.sram_gnt = 1'b1;
        #1 chk("t3_addr_g", bus.sram_addr, 28'h300);
        @(negedge clk);
        chk("t3_a0", bus.ack_vld, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_vld", bus.ack_vld, 1);
            chk("t3_id", bus.ack_entry_id, 7'(9 + i));
        end
        @(negedge clk);
        chk("t3_end", bus.ack_vld, 0);
        bus.sram_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'h4000 + 32'(i) * 16, 7'(30 + i));
            #1 chk("t4_acc", bus.req_rdy, 1);
            @(negedge clk);
        end
        put(32'h4040, 7'd34);
        bus.sram_gnt = 1'b1;
        #1 chk("t4_full", bus.req_rdy, 0);
        @(negedge clk);
        #1 chk("t4_acc34", bus.req_rdy, 1);
        @(negedge clk);
        put(32'h4050, 7'd35);
        bus.sram_gnt = 1'b0;
        clear = 1'b1;
        #1;
        chk("t4_clr_vld", bus.ack_vld, 1);
        chk("t4_clr_id", bus.ack_entry_id, 30);
        chk("t4_clr_rdy", bus.req_rdy, 0);
        chk("t4_clr_en", bus.sram_en, 0);
        @(negedge clk);
        clear = 1'b0;
        bus.req_vld = 1'b0;
        bus.sram_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t4_quiet", bus.ack_vld, 0);
            chk("t4_pld0", bus.ack_pld, 0);
            chk("t4_en", bus.sram_en, 0);
            @(negedge clk);
        end
        single("t4_next", 32'h4460, 7'd36);
        ack_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            put(32'h5000 + 32'(i) * 16, 7'(40 + i));
            #1 chk("t5_rdy", bus.req_rdy, 1);
            @(negedge clk);
        end
        bus.req_vld = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_n", ack_cyc.size(), 10);
        for (int i = 1; i < ack_cyc.size(); i++) chk("t5_gap", ack_cyc[i] - ack_cyc[i-1], 1);
        for (int i = 0; i < 4; i++) begin
            put(32'h6000 + 32'(i) * 16, 7'(50 + i));
            if (i < 3) @(negedge clk);
        end
        #1 chk("t6_pre_vld", bus.ack_vld, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rdy", bus.req_rdy, 0);
        chk("t6_en", bus.sram_en, 0);
        chk("t6_addr", bus.sram_addr, 0);
        chk("t6_vld", bus.ack_vld, 0);
        chk("t6_pld", bus.ack_pld, 0);
        chk("t6_id", bus.ack_entry_id, 0);
        @(negedge clk);
        #1 chk("t6_hold_en", bus.sram_en, 0);
        bus.req_vld = 1'b0;
        rst = 1'b0;
        #1 chk("t6_rel_rdy", bus.req_rdy, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t6_quiet", bus.ack_vld, 0);
        end
        single("t6_next", 32'h6100, 7'd60);
        repeat (2) @(negedge clk);
        chk("end_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/toy_fetch_mem_resp.md
TOY_FETCH_MEM_RESP -- requirements
Module: toy_fetch_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: fetch PC width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128: fetch line data width in bits, equal to the fetch queue's ack payload width.
REQ-003 SHALL have parameter ID_WIDTH, default 7: fetch queue entry-id width.
REQ-004 SHALL have parameter DEPTH, default 4, power of two >=2: request FIFO depth.
REQ-005 SHALL have parameter LATENCY, default 2, >=1: SRAM read latency in cycles.
REQ-006 SHALL have port clk, input, 1: sole clock.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port clear, input, 1: flush all queued and in-flight requests.
REQ-009 SHALL have port req_vld, input, 1: fetch request valid.
REQ-010 SHALL have port req_rdy, output, 1: request accepted when req_vld and req_rdy are both 1.
REQ-011 SHALL have port req_pc, input, ADDR_WIDTH: fetch PC.
REQ-012 SHALL have port req_entry_id, input, ID_WIDTH: fetch-queue entry allocated to the request.
REQ-013 SHALL have port sram_en, output, 1: SRAM read request.
REQ-014 SHALL have port sram_gnt, input, 1: SRAM accepts the read this cycle.
REQ-015 SHALL have port sram_addr, output, ADDR_WIDTH-log2(LINE_WIDTH/8): line index.
REQ-016 SHALL have port sram_rdata, input, LINE_WIDTH: read data, valid exactly LATENCY cycles after the grant cycle.
REQ-017 SHALL have port ack_vld, output, 1: response valid. There is no ready; the consumer always accepts.
REQ-018 SHALL have port ack_pld, output, LINE_WIDTH: response line.
REQ-019 SHALL have port ack_entry_id, output, ID_WIDTH: entry id of the response.

Function
REQ-020 SHALL hold accepted {line index, entry id} in a DEPTH-entry FIFO with wrapping read/write pointers and a count of width log2(DEPTH)+1.
REQ-021 SHALL compute req_rdy = (count < DEPTH) & ~clear from registered state only. A push and a pop in the same cycle leave count unchanged.
REQ-022 SHALL drive sram_en = FIFO non-empty & ~clear, and sram_addr = FIFO head line index. The head pops only on sram_en & sram_gnt.
REQ-023 SHALL, on sram_en & ~sram_gnt, hold sram_en and sram_addr stable until granted.
REQ-024 SHALL track each grant in a LATENCY-stage shift pipeline of {valid, entry id}, advancing every cycle.
REQ-025 SHALL drive ack_vld = last stage valid and ack_entry_id = last stage id. ack_pld SHALL pass sram_rdata through combinationally, and SHALL be forced to zero when ack_vld=0.
REQ-026 SHALL return responses in grant order. Minimum latency from request accept to ack_vld is 1+LATENCY cycles.
REQ-027 SHALL, on clear, reset the FIFO pointers and count to 0 and clear all pipeline valid bits at the next edge. A request presented in the clear cycle is dropped. The SRAM read completing in the clear cycle still produces ack_vld that cycle.
REQ-028 SHALL, when a pointer reaches DEPTH-1, wrap it to 0 with no bubble.

Reset
REQ-029 SHALL, while rst=1, asynchronously force pointers, count and pipeline valids to 0.
REQ-030 SHALL, while rst=1, output req_rdy=0, sram_en=0, ack_vld=0, ack_pld=0, ack_entry_id=0 and sram_addr=0.
REQ-031 SHALL, after rst deasserts mid-operation, emit no ack for requests accepted before reset. req_rdy=1 the first cycle after release.

Configuration
REQ-032 SHALL support macro TOY_FETCH_MEM_RESP_BYPASS_EN.
- When defined: if the FIFO is empty, req_vld=1 and clear=0, the request drives sram_en/sram_addr in its accept cycle. If also granted, it skips the FIFO, giving minimum latency LATENCY.
- When defined: if the bypassed request is not granted, it is pushed into the FIFO instead.
- When undefined: no bypass path exists and REQ-026 latency applies.

Verification
REQ-033 SHALL test single request: LATENCY=2, sram_gnt=1, req_pc=0x1010, req_entry_id=5 -> sram_addr=0x101 one cycle after accept; ack_vld=1 with ack_entry_id=5 three cycles after accept (two with bypass).
REQ-034 SHALL test full: sram_gnt=0, 4 requests accepted -> req_rdy=0. A 5th request is held, then accepted the cycle after the first grant.
REQ-035 SHALL test stall: sram_gnt low for 3 cycles with the head at id 9 -> sram_addr stable. id 9 acks LATENCY cycles after the grant, followed by ids 10 and 11 in order.
REQ-036 SHALL test clear: clear with 3 queued and 2 in flight -> at most one ack in the clear cycle, none afterwards. The next request acks normally.
REQ-037 SHALL test wrap: 10 back-to-back requests with continuous grant -> 10 acks with ids in order, no gaps after the first.
REQ-038 SHALL test async reset: rst pulse mid-stream -> all outputs 0 immediately, no stale acks after release.
